// File: rtl/d16i_irq_ctrl.sv
// Interrupt controller for the d16i core: latches up to 16 sources and services them lowest-index-first.
// Define D16I_IRQ_LEVEL_EN for level-sensitive sources; the default build is edge-triggered.
module d16i_irq_ctrl #(
    parameter int unsigned N_SRC     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter logic [7:0]  VEC_BASE  = 8'h00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic [15:0]      addr,
    input  logic [15:0]      wdata,
    input  logic             wr,
    output logic [15:0]      rdata,
    output logic             hit,
    output logic             irq,
    output logic [7:0]       irq_id
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [15:0] VALID = 16'hFFFF >> (16 - N_SRC);

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] mask_q, mask_d;
    logic [7:0]  irq_id_q, irq_id_d;
    logic [15:0] src16, set_vec, clr_vec, req, win_oh, offs;
    logic [3:0]  win_idx;
    logic        win_vld, take;
    logic        we_pend, we_mask, we_eoi;

    assign src16   = 16'(src);
    assign offs    = addr - BASE_ADDR;
    assign hit     = (addr >= BASE_ADDR) && (offs < 16'd4);
    assign we_pend = wr && hit && (offs[1:0] == 2'd0);
    assign we_mask = wr && hit && (offs[1:0] == 2'd1);
    assign we_eoi  = wr && hit && (offs[1:0] == 2'd2);

`ifdef D16I_IRQ_LEVEL_EN
    assign set_vec = src16;
`else
    logic [15:0] src_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) src_q <= '0;
        else     src_q <= src16;
    end

    assign set_vec = src16 & ~src_q;
`endif

    assign req = pending_q & mask_q;

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) begin
                win_idx = 4'(i);
                win_vld = 1'b1;
            end
        end
    end

    assign win_oh = 16'd1 << win_idx;

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        take     = 1'b0;
        if (state_q == S_IDLE) begin
            if (win_vld) begin
                take     = 1'b1;
                state_d  = S_ACTIVE;
                irq_id_d = VEC_BASE + {4'd0, win_idx};
            end
        end else if (we_eoi) begin
            state_d = S_IDLE;
        end
    end

    // A new set in the same cycle as a W1C or a take wins over the clear.
    assign clr_vec   = we_pend ? wdata : 16'd0;
    assign pending_d = ((pending_q & ~clr_vec & ~(take ? win_oh : 16'd0)) | set_vec) & VALID;
    assign mask_d    = we_mask ? (wdata & VALID) : mask_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            irq_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            irq_id_q  <= irq_id_d;
        end
    end

    assign irq    = (state_q == S_ACTIVE);
    assign irq_id = irq_id_q;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offs[1:0])
                2'd0:    rdata = pending_q;
                2'd1:    rdata = mask_q;
                2'd2:    rdata = '0;
                default: rdata = {7'd0, irq, irq_id_q};
            endcase
        end
    end

endmodule

// File: doc/d16i_irq_ctrl.md
# d16i_irq_ctrl

Interrupt controller that drives the `irq` and `irq_id` inputs of the d16i `core`. It collects up to 16 peripheral interrupt sources and latches them as pending. It selects the highest-priority unmasked source and holds `irq` high with a stable `irq_id` until the core writes end-of-interrupt. Its register window is on the core's single-cycle memory bus (`addr`, `dout`, `wr`, `din`), which it decodes as a responder.

## Interface
Parameters:
- `N_SRC`, 8: number of interrupt sources, 1..16.
- `BASE_ADDR`, 16'hFF00: word address of register 0. The window is 4 words.
- `VEC_BASE`, 8'h00: added to the source index to form `irq_id`.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `src`  in  N_SRC  interrupt request lines, synchronous to `clk`.
- `addr`  in  16  core bus address.
- `wdata`  in  16  core write data (core `dout`).
- `wr`  in  1  core write strobe.
- `rdata`  out  16  read data, combinational from `addr`. Muxed into core `din` when `hit`=1.
- `hit`  out  1  combinational: `addr` is within the 4-word window.
- `irq`  out  1  interrupt request to the core.
- `irq_id`  out  8  vector of the in-service source.

## Operation
Registers (offset from `BASE_ADDR`):
- +0 PENDING: read returns the pending bits. A write clears each bit written as 1 (W1C).
- +1 MASK: read/write. A mask bit of 1 enables that source.
- +2 EOI: a write of any value ends service. Reads return 0.
- +3 STATUS: read returns {7'b0, irq, irq_id}. Writes are ignored.
- Bits at or above N_SRC read as 0 and ignore writes.

Pending capture:
- Edge mode (default): `pending[i]` is set at a rising edge where `src[i]`=1 and `src_q[i]`=0. `src_q` is the `src` value registered at the previous edge.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.

State machine:
- IDLE to ACTIVE when `pending & mask` is nonzero. The winner is the lowest index. On the transition, register `irq_id` = VEC_BASE + index, clear `pending[index]`, and drive `irq`=1.
- ACTIVE to IDLE on an EOI write. `irq` goes to 0 and `irq_id` holds its last value.
- An EOI write while in IDLE is ignored.
- In ACTIVE, changes to MASK or PENDING do not affect `irq` or `irq_id`.
- A new edge on the in-service source sets pending again. That source is serviced after EOI, subject to priority.
- An address outside the window gives `hit`=0 and `rdata`=0, and writes have no effect.

## Timing
- Reset values: `irq`=0, `irq_id`=0, state IDLE, PENDING=0, MASK=0 (all masked), `src_q`=0. A source that is already high when `rst` deasserts registers as an edge.
- A register write takes effect at the rising edge where `wr`=1. The new value is readable the following cycle.
- Latency: `src` rises before edge k, so pending is set at edge k and `irq`=1 after edge k+1. This latency is 2 edges.
- EOI at edge e gives `irq`=0 after edge e. The earliest next `irq`=1 is after edge e+1, so there is at least one low cycle between services.
- If MASK is written with a bit whose source is already pending while in IDLE, `irq` goes high 1 edge after the MASK write edge.
- Reset asserted mid-service forces all outputs and registers to their reset values immediately, without waiting for a clock edge.

## Configuration
- `D16I_IRQ_LEVEL_EN` defined: sources are level-sensitive.
  - `pending[i]` is set on every edge while `src[i]`=1.
  - A W1C clear only sticks once `src[i]` is low.
  - `src_q` is not implemented.
- Macro undefined: edge-triggered behaviour exactly as described above.

## Test plan
- Reset state: hold `rst`=1, then release. Check `irq`=0 and `irq_id`=0. Reads of +0, +1 and +3 return 16'h0000.
- Single source:
  - Write MASK=16'h0004, then pulse `src[2]` for 1 cycle.
  - `irq`=1 two edges later, with `irq_id`=8'h02 and PENDING=0.
  - STATUS reads 16'h0102.
  - Writing EOI gives `irq`=0 next cycle.
- Priority: MASK=16'h00FF, then pulse `src[5]` and `src[1]` together.
  - The first service is `irq_id`=1, with PENDING=16'h0020.
  - After EOI, one cycle with `irq`=0, then `irq_id`=5.
- Masking and W1C:
  - MASK=0, pulse `src[3]`: PENDING=16'h0008 and `irq` stays 0.
  - Write PENDING=16'h0008: PENDING reads 0.
  - Pulse `src[3]` again, then write MASK=16'h0008: `irq`=1 one edge after the write.
- Set/clear collision: W1C of bit 0 in the same cycle as a `src[0]` edge leaves PENDING=16'h0001.
- Async reset mid-service:
  - With `irq`=1 and `irq_id`=3, assert `rst` between clock edges: `irq`=0 and `irq_id`=0 before the next edge.
  - With `VEC_BASE`=8'h20, a service of `src[0]` gives `irq_id`=8'h20.
